// File: rtl/bat_register_bank.sv
// Eight-register bank driven by one-hot controller strobes: A/B exposed to the ALU,
// and every update of OUT (reg 7) queued into a small first-word-fall-through FIFO.
module bat_register_bank #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       REGS_INC,
  input  logic [7:0]       REGS_RW,
  input  logic [7:0]       REGS_EN,
  input  logic [WIDTH-1:0] BUS_IN,
  output logic [WIDTH-1:0] BUS_OUT,
  output logic             BUS_DRIVE,
  output logic             BUS_CONFLICT,
  output logic [WIDTH-1:0] REG_A,
  output logic [WIDTH-1:0] REG_B,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             OUT_OVERFLOW
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic [7:0]       rd_sel;
  logic [7:0]       wr_sel;
  logic [7:0]       inc_sel;

  assign rd_sel  = REGS_EN & REGS_RW;
  assign wr_sel  = REGS_EN & ~REGS_RW;
  assign inc_sel = REGS_INC & ~REGS_RW;

  // Lowest-index reader wins the bus; iterate downward so it is assigned last.
  always_comb begin
    BUS_OUT = '0;
    for (int i = 7; i >= 0; i--) begin
      if (rd_sel[i]) BUS_OUT = regs_q[i];
    end
  end

  assign BUS_DRIVE    = |rd_sel;
  assign BUS_CONFLICT = |(rd_sel & (rd_sel - 8'd1));

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_reg
      // A bus write takes precedence over an increment in the same cycle.
      always_comb begin
        regs_d[gi] = regs_q[gi];
        if (wr_sel[gi])       regs_d[gi] = BUS_IN;
        else if (inc_sel[gi]) regs_d[gi] = regs_q[gi] + WIDTH'(1);
      end

      always_ff @(posedge CLK) begin
        if (!RST) regs_q[gi] <= '0;
        else      regs_q[gi] <= regs_d[gi];
      end
    end
  endgenerate

  assign REG_A = regs_q[0];
  assign REG_B = regs_q[1];

  // OUT queue
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             overflow_q;
  logic             push, push_eff, pop, full, empty;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push     = wr_sel[7] | inc_sel[7];
  assign pop      = ~empty & OUT_READY;
  assign push_eff = push & (~full | pop);
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push_eff);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

  // Next head: the freshly pushed word only when it lands in the head slot.
  always_comb begin
    out_data_d = '0;
    if (wr_ptr_d != rd_ptr_d) begin
      if (push_eff && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) out_data_d = regs_d[7];
      else                                                    out_data_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge CLK) begin
    if (push_eff) mem_q[wr_ptr_q[AW-1:0]] <= regs_d[7];
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      out_data_q <= out_data_d;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign OUT_DATA     = out_data_q;
  assign OUT_VALID    = ~empty;
  assign OUT_OVERFLOW = overflow_q;

endmodule

// File: tb/tb_bat_register_bank.sv
// Directed bench for bat_register_bank: register read/write/increment paths and the OUT FIFO.
module tb_bat_register_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] regs_inc, regs_rw, regs_en, bus_in;
  logic [7:0] bus_out, reg_a, reg_b, out_data;
  logic       bus_drive, bus_conflict, out_valid, out_ready, out_overflow;

  int checks = 0;
  int errors = 0;

  bat_register_bank #(.WIDTH(8), .FIFO_DEPTH(4)) dut (
    .CLK(clk), .RST(rst),
    .REGS_INC(regs_inc), .REGS_RW(regs_rw), .REGS_EN(regs_en),
    .BUS_IN(bus_in), .BUS_OUT(bus_out), .BUS_DRIVE(bus_drive), .BUS_CONFLICT(bus_conflict),
    .REG_A(reg_a), .REG_B(reg_b),
    .OUT_DATA(out_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT_OVERFLOW(out_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  // Apply strobes after the falling edge, clock them in, settle 1 time unit.
  task automatic cycle(input logic [7:0] inc, input logic [7:0] rw,
                       input logic [7:0] en, input logic [7:0] bus);
    @(negedge clk);
    regs_inc = inc; regs_rw = rw; regs_en = en; bus_in = bus;
    @(posedge clk);
    #1;
  endtask

  // Drive a combinational read request (no state change) and settle.
  task automatic set_read(input logic [7:0] en);
    @(negedge clk);
    regs_inc = 8'h00; regs_rw = en; regs_en = en; bus_in = 8'h00;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    regs_inc = 8'h00; regs_rw = 8'h00; regs_en = 8'h00; out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] rv;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      regs_inc = 8'($urandom); regs_rw = 8'($urandom); regs_en = 8'($urandom);
      bus_in = 8'($urandom); out_ready = 1'($urandom);
      @(posedge clk); #1;
      @(negedge clk);
    end
    rst = 1'b1;
    regs_inc = 8'h00; regs_rw = 8'h00; regs_en = 8'h00; out_ready = 1'b0;
    #1;
    checks++; if (reg_a !== 8'h00) begin errors++; $display("FAIL reset_reg_a got %h want 00", reg_a); end
    checks++; if (reg_b !== 8'h00) begin errors++; $display("FAIL reset_reg_b got %h want 00", reg_b); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", out_overflow); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    checks++; if (bus_out !== 8'h00 || bus_drive !== 1'b0) begin
      errors++; $display("FAIL reset_bus_idle got %h/%b want 00/0", bus_out, bus_drive);
    end
    for (int r = 2; r < 8; r++) begin
      rv = 8'h01 << r;
      set_read(rv);
      checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got %h want 00", r, bus_out); end
    end
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    cycle(8'h00, 8'h00, 8'h04, 8'h5A);
    set_read(8'h04);
    checks++; if (bus_out !== 8'h5A) begin errors++; $display("FAIL read_reg2 got %h want 5a", bus_out); end
    checks++; if (bus_drive !== 1'b1) begin errors++; $display("FAIL read_drive got %b want 1", bus_drive); end
    checks++; if (bus_conflict !== 1'b0) begin errors++; $display("FAIL read_noconflict got %b want 0", bus_conflict); end
    // Write reg 0 while reading reg 2: A updates, the read is unaffected.
    cycle(8'h00, 8'h04, 8'h05, 8'hFF);
    checks++; if (reg_a !== 8'hFF) begin errors++; $display("FAIL write_reg_a got %h want ff", reg_a); end
    cycle(8'h01, 8'h00, 8'h00, 8'h00);
    checks++; if (reg_a !== 8'h00) begin errors++; $display("FAIL inc_wrap_a got %h want 00", reg_a); end
    cycle(8'h01, 8'h00, 8'h00, 8'h00);
    checks++; if (reg_a !== 8'h01) begin errors++; $display("FAIL inc_a got %h want 01", reg_a); end
    // Increment while RW=1 is ignored.
    cycle(8'h02, 8'h02, 8'h00, 8'h00);
    checks++; if (reg_b !== 8'h00) begin errors++; $display("FAIL inc_rw_ignored got %h want 00", reg_b); end
    // MOV B <- A: bus fed from the previously read value, written into B.
    set_read(8'h01);
    checks++; if (bus_out !== 8'h01) begin errors++; $display("FAIL read_a got %h want 01", bus_out); end
    cycle(8'h00, 8'h01, 8'h03, bus_out);
    checks++; if (reg_b !== 8'h01) begin errors++; $display("FAIL mov_b got %h want 01", reg_b); end
    $display("test_write_read done");
  endtask

  task automatic test_write_priority();
    cycle(8'h08, 8'h00, 8'h08, 8'h10);
    set_read(8'h08);
    checks++; if (bus_out !== 8'h10) begin errors++; $display("FAIL write_over_inc got %h want 10", bus_out); end
    $display("test_write_priority done");
  endtask

  task automatic test_conflict();
    cycle(8'h00, 8'h00, 8'h10, 8'h44);
    cycle(8'h00, 8'h00, 8'h40, 8'h66);
    set_read(8'h50);
    checks++; if (bus_out !== 8'h44) begin errors++; $display("FAIL conflict_data got %h want 44", bus_out); end
    checks++; if (bus_conflict !== 1'b1) begin errors++; $display("FAIL conflict_flag got %b want 1", bus_conflict); end
    set_read(8'h40);
    checks++; if (bus_out !== 8'h66 || bus_conflict !== 1'b0) begin
      errors++; $display("FAIL read_reg6 got %h/%b want 66/0", bus_out, bus_conflict);
    end
    $display("test_conflict done");
  endtask

  task automatic test_overflow();
    logic [7:0] exp_seq [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    out_ready = 1'b0;
    cycle(8'h00, 8'h00, 8'h80, 8'h01);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin
      errors++; $display("FAIL push_latency got %b/%h want 1/01", out_valid, out_data);
    end
    for (int v = 2; v <= 5; v++) cycle(8'h00, 8'h00, 8'h80, 8'(v));
    checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %b want 1", out_overflow); end
    set_read(8'h80);
    checks++; if (bus_out !== 8'h05) begin errors++; $display("FAIL reg7_after_drop got %h want 05", bus_out); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      regs_en = 8'h00; regs_rw = 8'h00; out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== exp_seq[k]) begin
        errors++; $display("FAIL drain%0d got %b/%h want 1/%h", k, out_valid, out_data, exp_seq[k]);
      end
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", out_valid); end
    checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b want 1", out_overflow); end
    do_reset();
    #1;
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL overflow_cleared got %b want 0", out_overflow); end
    $display("test_overflow done");
  endtask

  task automatic test_full_pushpop();
    logic [7:0] exp_seq [4] = '{8'h22, 8'h33, 8'h44, 8'h99};
    out_ready = 1'b0;
    cycle(8'h00, 8'h00, 8'h80, 8'h11);
    cycle(8'h00, 8'h00, 8'h80, 8'h22);
    cycle(8'h00, 8'h00, 8'h80, 8'h33);
    cycle(8'h00, 8'h00, 8'h80, 8'h44);
    checks++; if (out_overflow !== 1'b0 || out_data !== 8'h11) begin
      errors++; $display("FAIL fill_four got %b/%h want 0/11", out_overflow, out_data);
    end
    @(negedge clk);
    out_ready = 1'b1;
    regs_inc = 8'h00; regs_rw = 8'h00; regs_en = 8'h80; bus_in = 8'h99;
    @(posedge clk); #1;
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf got %b want 0", out_overflow); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      regs_en = 8'h00;
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== exp_seq[k]) begin
        errors++; $display("FAIL pushpop_drain%0d got %b/%h want 1/%h", k, out_valid, out_data, exp_seq[k]);
      end
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pushpop_empty got %b want 0", out_valid); end
    $display("test_full_pushpop done");
  endtask

  task automatic test_back_to_back();
    // Increment of reg 7 pushes; push with READY=1 while empty is a push only.
    out_ready = 1'b1;
    cycle(8'h80, 8'h00, 8'h00, 8'h00);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h9A) begin
      errors++; $display("FAIL inc7_push got %b/%h want 1/9a", out_valid, out_data);
    end
    cycle(8'h80, 8'h00, 8'h00, 8'h00);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h9B) begin
      errors++; $display("FAIL inc7_stream got %b/%h want 1/9b", out_valid, out_data);
    end
    cycle(8'h00, 8'h00, 8'h00, 8'h00);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_empty got %b want 0", out_valid); end
    $display("test_back_to_back done");
  endtask

  initial begin
    rst = 1'b0; regs_inc = 8'h00; regs_rw = 8'h00; regs_en = 8'h00;
    bus_in = 8'h00; out_ready = 1'b0;
    test_reset();
    test_write_read();
    test_write_priority();
    test_conflict();
    test_overflow();
    test_full_pushpop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
